// File: rtl/pad_scan_encoder.sv
// pad_scan_encoder
//   Scans a 4x4 pad matrix one column at a time, samples the synchronized row
//   returns into a per-frame map, and debounces single-key frames into a
//   4-bit code (row*4 + col) for the downstream pad decoder.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   col_out    : column drive, active-low, one-hot-low
//   row_in     : row returns, active-low, asynchronous to clk
//   key_code   : last accepted pad code, cleared only by reset
//   key_valid  : one-cycle pulse per accepted press (and per auto-repeat)
//   key_held   : high while the accepted key is debounced-pressed
//
// Build option
//   PAD_SCAN_REPEAT_EN : when defined, adds auto-repeat pulses on key_valid
//                        controlled by REPEAT_DELAY / REPEAT_RATE (in frames).
//
// State table
//   S_IDLE    | no key; waiting for a single-key frame
//   S_CONFIRM | candidate key seen; counting identical frames
//   S_PRESSED | key accepted; key_held high
//   S_RELEASE | held key missing; counting frames before dropping key_held
module pad_scan_encoder #(
  parameter int CLK_DIV  = 4,
  parameter int DEBOUNCE = 3
`ifdef PAD_SCAN_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 32,
  parameter int REPEAT_RATE  = 8
`endif
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] col_out,
  input  logic [3:0] row_in,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONFIRM,
    S_PRESSED,
    S_RELEASE
  } state_t;

  logic [3:0]       row_meta_q, row_sync_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic [15:0]      map_q, map_d;
  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       code_q, code_d;
  logic             valid_q, valid_d;

  logic             slot_last;
  logic             frame_end;
  logic [4:0]       ones;
  logic [3:0]       hit_code;
  logic             single;
  logic             held_seen;
  logic [4:0]       cnt_inc;
  logic             cnt_done;

`ifdef PAD_SCAN_REPEAT_EN
  logic [15:0]      rep_cnt_q, rep_cnt_d;
  logic             rep_phase_q, rep_phase_d;
  logic [15:0]      rep_next;
  logic [15:0]      rep_target;
`endif

  // Row returns are asynchronous; two flops before any use. Idle rows read high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= row_in;
      row_sync_q <= row_meta_q;
    end
  end

  // Column slot timing
  always_comb begin
    slot_last = (div_q == DIV_W'(CLK_DIV - 1));
    frame_end = slot_last && (col_q == 2'd3);
    div_d     = slot_last ? '0 : div_q + 1'b1;
    col_d     = slot_last ? col_q + 2'd1 : col_q;
  end

  // Every bit of the map is rewritten once per frame, so no clear is needed.
  // map_d already contains the column-3 samples when the frame is evaluated.
  always_comb begin
    map_d = map_q;
    if (slot_last) begin
      for (int r = 0; r < 4; r++) begin
        map_d[r*4 + int'(col_q)] = ~row_sync_q[r];
      end
    end
  end

  always_comb begin
    ones     = '0;
    hit_code = '0;
    for (int i = 0; i < 16; i++) begin
      if (map_d[i]) begin
        ones     = ones + 5'd1;
        hit_code = 4'(i);
      end
    end
    // Two or more keys are indistinguishable from ghosts; treat as empty.
    single    = (ones == 5'd1);
    held_seen = single && (hit_code == code_q);
    cnt_inc   = {1'b0, cnt_q} + 5'd1;
    cnt_done  = (cnt_inc >= 5'(DEBOUNCE));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    code_d  = code_q;
    valid_d = 1'b0;
`ifdef PAD_SCAN_REPEAT_EN
    rep_cnt_d   = rep_cnt_q;
    rep_phase_d = rep_phase_q;
    rep_next    = rep_cnt_q + 16'd1;
    rep_target  = rep_phase_q ? 16'(REPEAT_RATE) : 16'(REPEAT_DELAY);
`endif
    if (frame_end) begin
      unique case (state_q)
        S_IDLE: begin
          if (single) begin
            cand_d = hit_code;
            cnt_d  = 4'd1;
            if (DEBOUNCE <= 1) begin
              state_d = S_PRESSED;
              code_d  = hit_code;
              valid_d = 1'b1;
`ifdef PAD_SCAN_REPEAT_EN
              rep_cnt_d   = '0;
              rep_phase_d = 1'b0;
`endif
            end else begin
              state_d = S_CONFIRM;
            end
          end
        end
        S_CONFIRM: begin
          if (single && (hit_code == cand_q)) begin
            if (cnt_done) begin
              state_d = S_PRESSED;
              code_d  = cand_q;
              valid_d = 1'b1;
`ifdef PAD_SCAN_REPEAT_EN
              rep_cnt_d   = '0;
              rep_phase_d = 1'b0;
`endif
            end else begin
              cnt_d = cnt_inc[3:0];
            end
          end else if (single) begin
            cand_d = hit_code;
            cnt_d  = 4'd1;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        S_PRESSED: begin
          // A different key also lands here: it must release before it can confirm.
          if (!held_seen) begin
            if (DEBOUNCE <= 1) begin
              state_d = S_IDLE;
              cnt_d   = '0;
`ifdef PAD_SCAN_REPEAT_EN
              rep_phase_d = 1'b0;
`endif
            end else begin
              state_d = S_RELEASE;
              cnt_d   = 4'd1;
            end
`ifdef PAD_SCAN_REPEAT_EN
            rep_cnt_d = '0;
`endif
          end else begin
`ifdef PAD_SCAN_REPEAT_EN
            if (rep_next == rep_target) begin
              valid_d     = 1'b1;
              rep_cnt_d   = '0;
              rep_phase_d = 1'b1;
            end else begin
              rep_cnt_d = rep_next;
            end
`else
            // Without auto-repeat a held key produces no further pulses.
            valid_d = 1'b0;
`endif
          end
        end
        S_RELEASE: begin
          if (held_seen) begin
            // The repeat phase survives a bounce, so the initial delay is not rerun.
            state_d = S_PRESSED;
            cnt_d   = '0;
          end else if (cnt_done) begin
            state_d = S_IDLE;
            cnt_d   = '0;
`ifdef PAD_SCAN_REPEAT_EN
            rep_phase_d = 1'b0;
`endif
          end else begin
            cnt_d = cnt_inc[3:0];
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      col_q   <= '0;
      map_q   <= '0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      col_q   <= col_d;
      map_q   <= map_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

`ifdef PAD_SCAN_REPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_phase_q <= rep_phase_d;
    end
  end
`endif

  assign col_out   = ~(4'b0001 << col_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = (state_q == S_PRESSED) || (state_q == S_RELEASE);

endmodule

// File: tb/tb_pad_scan_encoder.sv
module tb_pad_scan_encoder;

  typedef struct {
    logic [3:0] code;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] col_out;
  logic [3:0] row_in;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys;
  int          cyc;
  int          checks;
  int          errors;
  exp_t        exp_q[$];

  pad_scan_encoder #(
    .CLK_DIV (4),
    .DEBOUNCE(3)
`ifdef PAD_SCAN_REPEAT_EN
    ,
    .REPEAT_DELAY(4),
    .REPEAT_RATE (2)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .col_out  (col_out),
    .row_in   (row_in),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pad matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
    end
  end

  // Cycle index equals the DUT slot/column timeline after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_pulse(input logic [3:0] code, input int at_cyc);
    exp_t e;
    e.code = code;
    e.cyc  = at_cyc;
    exp_q.push_back(e);
  endtask

  task automatic step_to(input int target);
    int guard;
    guard = 0;
    while (cyc < target && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != target) check("step_to_cycle", 32'(cyc), 32'(target));
  endtask

  // Scoreboard: every key_valid cycle pops the next expected pulse.
  always @(negedge clk) begin
    if (!rst && key_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid_pending", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("valid_code", 32'(key_code), 32'(e.code));
        check("valid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    keys   = '0;
    rst    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_col", 32'(col_out), 32'h0000000E);
    check("rst_code", 32'(key_code), 32'd0);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_held", 32'(key_held), 32'd0);
    rst = 1'b0;

    step_to(3);  check("col_slot0_end", 32'(col_out), 32'hE);
    step_to(4);  check("col_step1", 32'(col_out), 32'hD);
    step_to(8);  check("col_step2", 32'(col_out), 32'hB);
    step_to(12); check("col_step3", 32'(col_out), 32'h7);
    step_to(16); check("col_wrap", 32'(col_out), 32'hE);

    // Key 9 (row 2, col 1) held from frame 1; accepted after frame 3.
    keys = 16'h0200;
    expect_pulse(4'd9, 64);
    step_to(63); check("k9_held_before", 32'(key_held), 32'd0);
    step_to(64); check("k9_held", 32'(key_held), 32'd1);
    check("k9_code", 32'(key_code), 32'd9);
    step_to(96); check("k9_still_held", 32'(key_held), 32'd1);

    // Full release: three empty frames.
    keys = '0;
    step_to(143); check("rel_held_2frames", 32'(key_held), 32'd1);
    step_to(144); check("rel_held_drop", 32'(key_held), 32'd0);
    check("rel_code_kept", 32'(key_code), 32'd9);

    // Re-press, then a two-frame dropout that must not release or re-pulse.
    keys = 16'h0200;
    expect_pulse(4'd9, 192);
    step_to(192); keys = '0;
    step_to(208); check("bounce_rel1_held", 32'(key_held), 32'd1);
    step_to(224); check("bounce_rel2_held", 32'(key_held), 32'd1);
    keys = 16'h0200;
    step_to(240); check("bounce_back_held", 32'(key_held), 32'd1);
    step_to(256); keys = '0;
    step_to(303); check("rel2_held", 32'(key_held), 32'd1);
    step_to(304); check("rel2_drop", 32'(key_held), 32'd0);

    // Key 5 bounce: 2 present, 1 absent, 2 present, then gone.
    keys = 16'h0020;
    step_to(336); keys = '0;
    step_to(352); check("k5_gap_held", 32'(key_held), 32'd0);
    keys = 16'h0020;
    step_to(384); keys = '0;
    check("k5_held", 32'(key_held), 32'd0);
    step_to(400); check("k5_code_unchanged", 32'(key_code), 32'd9);

    // Keys 3 and 12 together: ghost-rejected; then key 3 alone.
    keys = 16'h1008;
    step_to(560); check("ghost_held", 32'(key_held), 32'd0);
    keys = 16'h0008;
    expect_pulse(4'd3, 608);
    step_to(607); check("k3_before", 32'(key_held), 32'd0);
    step_to(608); check("k3_held", 32'(key_held), 32'd1);
    check("k3_code", 32'(key_code), 32'd3);

    // Asynchronous reset while PRESSED.
    step_to(620);
    rst = 1'b1;
    #1;
    check("mid_rst_col", 32'(col_out), 32'hE);
    check("mid_rst_code", 32'(key_code), 32'd0);
    check("mid_rst_valid", 32'(key_valid), 32'd0);
    check("mid_rst_held", 32'(key_held), 32'd0);
    keys = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

`ifdef PAD_SCAN_REPEAT_EN
    // Auto-repeat: acceptance, +4 frames, then every 2 frames.
    step_to(16);
    keys = 16'h0200;
    expect_pulse(4'd9, 64);
    expect_pulse(4'd9, 128);
    expect_pulse(4'd9, 160);
    expect_pulse(4'd9, 192);
    step_to(192); keys = '0;
    step_to(260); check("rep_released", 32'(key_held), 32'd0);
`else
    step_to(100);
    check("post_rst_code", 32'(key_code), 32'd0);
`endif

    check("missing_pulses", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pad_scan_encoder.md
# pad_scan_encoder

Scans the 4x4 launch-pad button matrix, synchronizes and debounces the row returns, and encodes a single pressed pad into a 4-bit code. It sits directly upstream of the 4-bit pad decoder: `key_code` drives the decoder's `Din`, and code n lights decoder output p(n+1). `key_valid` marks each newly accepted press.

## Interface
- `CLK_DIV`, default 4: cycles each column is driven per scan slot; must be ≥ 4.
- `DEBOUNCE`, default 3: consecutive identical frames needed to accept a press or a release; range 1–15.
- `REPEAT_DELAY`, default 32: frames a key is held before the first auto-repeat. Used only with `PAD_SCAN_REPEAT_EN`.
- `REPEAT_RATE`, default 8: frames between auto-repeat pulses. Used only with `PAD_SCAN_REPEAT_EN`.
- `clk`, input, 1: the single clock; all state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `col_out`, output, 4: column drive, active-low, exactly one bit low.
- `row_in`, input, 4: row returns, active-low, pulled high externally, asynchronous.
- `key_code`, output, 4: last accepted pad code, `row*4 + col`.
- `key_valid`, output, 1: one-cycle pulse when `key_code` is accepted.
- `key_held`, output, 1: high while the accepted key is debounced-pressed.

## Operation
- **Reset values:** `col_out` = 4'b1110, `key_code` = 0, `key_valid` = 0, `key_held` = 0, FSM in IDLE, all counters 0.
- **Synchronizer:** `row_in` passes through a 2-flop synchronizer before any use.
- **Scan:** `col_out` steps 1110 → 1101 → 1011 → 0111 and wraps. Each column is held for `CLK_DIV` cycles, so one frame is 4*`CLK_DIV` cycles.
- **Sampling:** synchronized rows are sampled on the last cycle of each column slot and accumulated into a 16-bit frame map.
- **Frame result, evaluated on the last cycle of the column-3 slot:**
  - Exactly one bit set: single key, with code `row*4 + col`.
  - No bit set: empty.
  - Two or more bits set: treated as empty (ghost rejection).
- **FSM (debounce counter `cnt`):**
  - IDLE: single key → CONFIRM, `cnt` = 1, `cand` = code. Otherwise stay in IDLE.
  - CONFIRM:
    - Same code → `cnt`+1; when `cnt` reaches `DEBOUNCE` → PRESSED, load `key_code` = `cand`, pulse `key_valid`.
    - Different single code → stay in CONFIRM, `cnt` = 1, `cand` = new code.
    - Empty → IDLE.
  - PRESSED: `key_held` = 1. Any frame without the held code → RELEASE, `cnt` = 1.
  - RELEASE: `key_held` stays 1.
    - Frame without the held code → `cnt`+1; when `cnt` reaches `DEBOUNCE` → IDLE and `key_held` = 0.
    - Frame with the held code → back to PRESSED.
- With `DEBOUNCE` = 1: IDLE goes straight to PRESSED on the first single-key frame, and RELEASE returns to IDLE on the first frame without the held code.
- `key_code` is never cleared except by reset; it holds the last accepted code after release.
- A different key pressed while PRESSED counts as a release first; it is accepted only after the release completes and a new confirmation runs.

## Timing
- Frame evaluation happens on cycle 4*`CLK_DIV`−1 of the frame; `key_code`, `key_valid` and `key_held` update on the next rising edge.
- Press latency: a key that is stably low from the start of a frame produces `key_valid` 1 cycle after the end of the `DEBOUNCE`th frame.
- `key_valid` is high for exactly 1 cycle per acceptance, with no handshake; the decoder samples `key_code` continuously.
- The synchronizer delays rows by 2 cycles. `CLK_DIV` ≥ 4 guarantees the sample point is past settle plus sync.
- Reset is asynchronous: an assertion mid-frame or mid-press forces all reset values immediately. Scanning restarts at column 0, slot cycle 0, on the first edge after deassertion.

## Configuration
- `PAD_SCAN_REPEAT_EN` defined:
  - While PRESSED, a frame counter runs.
  - `key_valid` re-pulses, with `key_code` unchanged, after `REPEAT_DELAY` frames and then every `REPEAT_RATE` frames.
  - Entering RELEASE or IDLE stops and clears the counter; returning from RELEASE to PRESSED does not restart the delay.
- Undefined: exactly one `key_valid` per press. The repeat counter and its parameters are not built.

## Test plan
All scenarios use `CLK_DIV` = 4 and `DEBOUNCE` = 3, so one frame is 16 cycles.
- Assert `rst` for 3 cycles → `col_out` = 1110, `key_code` = 0, `key_valid` = 0, `key_held` = 0; first step to 1101 comes 4 cycles after release.
- Hold row 2 / column 1 low indefinitely → exactly one `key_valid` pulse with `key_code` = 9 (decoder p10) at the end of the 3rd full frame; `key_held` = 1.
- Bounce: key 5 present for 2 frames, absent for 1, present for 2 → no `key_valid`; `key_held` stays 0.
- Keys 3 and 12 pressed together for 10 frames → no `key_valid`. Then release 12 → key 3 is accepted after 3 frames.
- Release key 9 → `key_held` falls after 3 empty frames; `key_code` stays 9. Re-press within 2 frames → `key_held` stays high and no new pulse.
- Assert `rst` mid-PRESSED → immediate reset values. With `PAD_SCAN_REPEAT_EN`, `REPEAT_DELAY` = 4 and `REPEAT_RATE` = 2, holding key 9 → pulses at acceptance, +4 frames, then every 2 frames.
